instruction_fetch_queue: RTL and testbench

- Fetch stage directly upstream of the instruction decoder.
- Generates sequential instruction-memory requests from a PC register and buffers in-order responses with their PCs in a small FIFO.
- Presents one {pc, instruction} pair per cycle to decode through a valid/ready handshake.
- Handles control-flow redirects by flushing the queue and discarding stale in-flight responses.

---
 rtl/instruction_fetch_queue_pkg.sv | 22 ++
 rtl/ifq_fifo.sv | 63 ++++++
 rtl/instruction_fetch_queue.sv | 146 ++++++++++++++
 tb/tb_instruction_fetch_queue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_queue_pkg.sv
// rtl/instruction_fetch_queue_pkg.sv - fetch constants and queue entry type shared by the fetch stage
package instruction_fetch_queue_pkg;

  localparam logic [31:0] IFQ_NOP                  = 32'h0000_0013;
  localparam logic [31:0] IFQ_DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] IFQ_PC_INC               = 32'd4;

  // One decoded-side queue entry: the PC it was fetched from and the returned word
  typedef struct packed {
`ifdef IFQ_MISALIGN_CHECK_EN
    logic        misaligned;
`endif
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  // Word-align a fetch address
  function automatic logic [31:0] ifq_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// rtl/ifq_fifo.sv - synchronous FIFO with push, pop, flush, count and head outputs
module ifq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;

  // Flush empties the FIFO first, so a push in the same cycle lands as the only entry
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end
    if (push) begin
      mem_d[wr_ptr_d] = push_data;
      wr_ptr_d        = wr_ptr_d + 1'b1;
      count_d         = count_d + 1'b1;
    end
  end

  // Storage and pointer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - sequential fetch with in-order response queue; option IFQ_MISALIGN_CHECK_EN
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = IFQ_DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc
`ifdef IFQ_MISALIGN_CHECK_EN
  ,
  output logic        id_misaligned
`endif
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW+1:0]  DEPTH_W = (AW+2)'(DEPTH);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [AW:0] inflight_q, inflight_d;
  logic [AW:0] discard_q, discard_d;
  logic        fetch_stall;
  logic [AW:0] q_count, tag_count;
  logic [31:0] tag_head;
  logic [AW+1:0] credit_used;
  logic        req_fire, resp_live, q_push;
  ifq_entry_t  q_push_data, q_head;

`ifdef IFQ_MISALIGN_CHECK_EN
  logic stall_q, stall_d;
  logic redirect_misaligned;
  assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fetch_stall         = stall_q;
  assign q_push              = resp_live || redirect_misaligned;
`else
  assign fetch_stall         = 1'b0;
  assign q_push              = resp_live;
`endif

  // Queued entries plus live (non-discarded) requests must fit in the queue
  assign credit_used    = {1'b0, q_count} + {1'b0, inflight_q - discard_q};
  assign imem_req_valid = reset_n && !redirect_valid && !fetch_stall &&
                          (credit_used < DEPTH_W) && (inflight_q < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_live      = imem_resp_valid && !redirect_valid && (discard_q == '0);

  // Build the entry to enqueue: a live response, or the misaligned-redirect marker
  always_comb begin
    q_push_data       = '0;
    q_push_data.pc    = tag_head;
    q_push_data.instr = imem_resp_data;
`ifdef IFQ_MISALIGN_CHECK_EN
    if (redirect_misaligned) begin
      q_push_data.pc         = redirect_pc;
      q_push_data.instr      = IFQ_NOP;
      q_push_data.misaligned = 1'b1;
    end
`endif
  end

  // Next-state for fetch PC and request bookkeeping; a redirect overrides everything
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
`ifdef IFQ_MISALIGN_CHECK_EN
    stall_d    = stall_q;
`endif
    if (redirect_valid) begin
      inflight_d = inflight_q - {{AW{1'b0}}, imem_resp_valid};
      discard_d  = inflight_d;
`ifdef IFQ_MISALIGN_CHECK_EN
      fetch_pc_d = redirect_pc;
      stall_d    = redirect_misaligned;
`else
      fetch_pc_d = ifq_align(redirect_pc);
`endif
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + IFQ_PC_INC;
      inflight_d = inflight_q + {{AW{1'b0}}, req_fire} - {{AW{1'b0}}, imem_resp_valid};
      if (imem_resp_valid && (discard_q != '0)) discard_d = discard_q - 1'b1;
    end
  end

  // Fetch-side state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_VECTOR;
      inflight_q <= '0;
      discard_q  <= '0;
`ifdef IFQ_MISALIGN_CHECK_EN
      stall_q    <= 1'b0;
`endif
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
`ifdef IFQ_MISALIGN_CHECK_EN
      stall_q    <= stall_d;
`endif
    end
  end

  ifq_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (resp_live && (tag_count != '0)),
    .head_data (tag_head),
    .count     (tag_count)
  );

  ifq_fifo #(.WIDTH($bits(ifq_entry_t)), .DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (id_valid && id_ready),
    .head_data (q_head),
    .count     (q_count)
  );

  assign id_valid       = (q_count != '0);
  assign id_pc          = id_valid ? q_head.pc : 32'h0;
  assign id_instruction = id_valid ? q_head.instr : IFQ_NOP;
`ifdef IFQ_MISALIGN_CHECK_EN
  assign id_misaligned  = id_valid && q_head.misaligned;
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - randomized and directed checks of the fetch queue against a request-list model
module tb_instruction_fetch_queue;
  import instruction_fetch_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instruction, id_pc;
`ifdef IFQ_MISALIGN_CHECK_EN
  logic        id_misaligned;
`endif

  always #5 clk = ~clk;

  instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_VECTOR(32'h0)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instruction  (id_instruction),
    .id_pc           (id_pc)
`ifdef IFQ_MISALIGN_CHECK_EN
    ,
    .id_misaligned   (id_misaligned)
`endif
  );

  typedef struct { logic [31:0] pc; logic [31:0] data; bit mis; } ent_t;
  typedef struct { logic [31:0] addr; bit stale; } req_t;

  ent_t        mq[$];     // what decode should see, in order
  req_t        mo[$];     // requests issued and not yet answered
  logic [31:0] maddr[$];  // memory side: accepted addresses awaiting a response
  logic [31:0] m_pc;
  bit          m_stall;
  int          checks, failures;
  int          resp_pct;
  int          dut_fires;
  bit          obs_idv;
  logic [31:0] obs_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
    redirect_valid = 0; redirect_pc = 0; id_ready = 0;
    mq.delete(); mo.delete(); maddr.delete();
    m_pc = 32'h0; m_stall = 0;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_instr", id_instruction, IFQ_NOP);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // One clock: drive, check against model at the falling edge, update model at the rising edge
  task automatic cycle(input bit rdy, input bit idr, input bit redir, input logic [31:0] rpc);
    int   live;
    bit   exp_rv, exp_idv, exp_fire, pop, resp, dut_fire;
    logic [31:0] rdata, daddr;
    req_t r;
    imem_req_ready = rdy; id_ready = idr; redirect_valid = redir; redirect_pc = rpc;
    if (maddr.size() > 0 && int'($urandom_range(99)) < resp_pct) begin
      imem_resp_valid = 1; imem_resp_data = maddr[0] ^ 32'hA5A5_0000;
    end else begin
      imem_resp_valid = 0; imem_resp_data = $urandom;
    end
    @(negedge clk);
    live = 0;
    foreach (mo[i]) if (!mo[i].stale) live++;
    exp_rv  = !redir && !m_stall && (mq.size() + live < DEPTH) && (mo.size() < DEPTH);
    exp_idv = mq.size() != 0;
    chk("req_valid", imem_req_valid, exp_rv);
    chk("req_addr", imem_req_addr, m_pc);
    chk("id_valid", id_valid, exp_idv);
    chk("id_pc", id_pc, exp_idv ? mq[0].pc : 32'h0);
    chk("id_instr", id_instruction, exp_idv ? mq[0].data : IFQ_NOP);
`ifdef IFQ_MISALIGN_CHECK_EN
    chk("id_misaligned", id_misaligned, exp_idv ? mq[0].mis : 1'b0);
`endif
    obs_idv = id_valid; obs_pc = id_pc;
    exp_fire = exp_rv && rdy;
    pop      = exp_idv && idr;
    resp     = imem_resp_valid;
    rdata    = imem_resp_data;
    dut_fire = imem_req_valid && imem_req_ready;
    daddr    = imem_req_addr;
    @(posedge clk);
    if (resp) void'(maddr.pop_front());
    if (dut_fire) begin maddr.push_back(daddr); dut_fires++; end
    if (redir) begin
      if (resp && mo.size() > 0) void'(mo.pop_front());
      foreach (mo[i]) mo[i].stale = 1;
      mq.delete();
`ifdef IFQ_MISALIGN_CHECK_EN
      m_pc = rpc;
      m_stall = (rpc[1:0] != 2'b00);
      if (m_stall) mq.push_back('{rpc, IFQ_NOP, 1'b1});
`else
      m_pc = rpc & 32'hFFFF_FFFC;
`endif
    end else begin
      if (pop) void'(mq.pop_front());
      if (resp && mo.size() > 0) begin
        r = mo.pop_front();
        if (!r.stale) mq.push_back('{r.addr, rdata, 1'b0});
      end
      if (exp_fire) begin mo.push_back('{m_pc, 1'b0}); m_pc = m_pc + 32'd4; end
    end
    chk("no_overflow", (mq.size() <= DEPTH), 1);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0; resp_pct = 100; dut_fires = 0;
    do_reset();

    // Sequential streaming with a one-cycle memory
    repeat (12) cycle(1, 1, 0, 0);

    // Fill with decode stalled: exactly DEPTH requests after the flush
    cycle(1, 0, 1, 32'h200);
    dut_fires = 0;
    repeat (15) cycle(1, 0, 0, 0);
    chk("fill_req_count", dut_fires, DEPTH);
    repeat (10) cycle(1, 1, 0, 0);

    // Three requests outstanding, then redirect to 0x100
    cycle(1, 1, 1, 32'h300);
    resp_pct = 0;
    repeat (3) cycle(1, 1, 0, 0);
    resp_pct = 100;
    cycle(1, 1, 1, 32'h100);
    obs_idv = 0;
    for (int i = 0; i < 20 && !obs_idv; i++) cycle(1, 1, 0, 0);
    chk("first_pc_after_redirect", obs_pc, 32'h100);

    // Redirect coinciding with a response and a pop
    resp_pct = 50;
    repeat (6) cycle(1, 0, 0, 0);
    resp_pct = 100;
    cycle(1, 1, 1, 32'h400);
    repeat (6) cycle(1, 1, 0, 0);

    // Address wrap
    cycle(1, 1, 1, 32'hFFFF_FFF8);
    repeat (8) cycle(1, 1, 0, 0);

`ifdef IFQ_MISALIGN_CHECK_EN
    // Misaligned redirect: one marker entry, no fetches until the next redirect
    cycle(1, 0, 1, 32'h102);
    dut_fires = 0;
    repeat (6) cycle(1, 0, 0, 0);
    chk("misaligned_no_fetch", dut_fires, 0);
    repeat (3) cycle(1, 1, 0, 0);
    cycle(1, 1, 1, 32'h500);
    repeat (6) cycle(1, 1, 0, 0);
`endif

    // Reset in the middle of traffic
    repeat (3) cycle(1, 0, 0, 0);
    do_reset();
    repeat (6) cycle(1, 1, 0, 0);

    // Randomized traffic
    for (int blk = 0; blk < 30; blk++) begin
      resp_pct = int'($urandom_range(20, 100));
      for (int i = 0; i < 100; i++) begin
        logic [31:0] rpc;
        case ($urandom_range(3))
          0: rpc = $urandom;
          1: rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
          default: rpc = $urandom & 32'h0000_FFFC;
        endcase
        cycle($urandom_range(99) < 80, $urandom_range(99) < 70,
              $urandom_range(99) < 3, rpc);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
